// File: rtl/camera_power_pkg.sv
// Shared state encoding, power-good bit indices and output decode for the
// camera sensor power sequencer.
package camera_power_pkg;

  localparam int unsigned ST_W = 4;

  typedef logic [ST_W-1:0] state_t;

  // Encoding is ordered so that each enable is active over one contiguous range
  localparam state_t ST_OFF     = ST_W'(0);
  localparam state_t ST_UP_1V2  = ST_W'(1);
  localparam state_t ST_UP_1V8  = ST_W'(2);
  localparam state_t ST_UP_3V3  = ST_W'(3);
  localparam state_t ST_UP_INCK = ST_W'(4);
  localparam state_t ST_UP_XCLR = ST_W'(5);
  localparam state_t ST_ON      = ST_W'(6);
  localparam state_t ST_DN_XCLR = ST_W'(7);
  localparam state_t ST_DN_INCK = ST_W'(8);
  localparam state_t ST_DN_3V3  = ST_W'(9);
  localparam state_t ST_DN_1V8  = ST_W'(10);
  localparam state_t ST_DN_1V2  = ST_W'(11);
  localparam state_t ST_FAULT   = ST_W'(12);

  localparam int unsigned PG_1V2 = 0;
  localparam int unsigned PG_1V8 = 1;
  localparam int unsigned PG_3V3 = 2;

  typedef struct packed {
    logic reg_1v2_en;
    logic reg_1v8_en;
    logic reg_3v3_en;
    logic inck_en;
    logic xclr;
    logic busy;
    logic ready;
    logic fault;
  } pwr_out_t;

  function automatic pwr_out_t decode_outputs(input state_t st);
    pwr_out_t o;
    o.reg_1v2_en = (st >= ST_UP_1V2)  && (st <= ST_DN_1V8);
    o.reg_1v8_en = (st >= ST_UP_1V8)  && (st <= ST_DN_3V3);
    o.reg_3v3_en = (st >= ST_UP_3V3)  && (st <= ST_DN_INCK);
    o.inck_en    = (st >= ST_UP_INCK) && (st <= ST_DN_XCLR);
    o.xclr       = (st == ST_UP_XCLR) || (st == ST_ON);
    o.busy       = ((st >= ST_UP_1V2) && (st <= ST_UP_XCLR)) ||
                   ((st >= ST_DN_XCLR) && (st <= ST_DN_1V2));
    o.ready      = (st == ST_ON);
    o.fault      = (st == ST_FAULT);
    return o;
  endfunction

endpackage

// File: rtl/camera_power_step_timer.sv
// Saturating per-step cycle counter with registered step-done and
// power-good timeout flags that track the count value.
module camera_power_step_timer #(
  parameter int unsigned STEP_DELAY    = 1000000,
  parameter int unsigned PGOOD_TIMEOUT = 2000000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic step_done,
  output logic timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DELAY - 1);
  localparam logic [CNT_W-1:0] PG_LAST   = CNT_W'(PGOOD_TIMEOUT - 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (enable && (count != CNT_MAX)) begin
      count_next = count + CNT_W'(1);
    end
  end

  // Flags are registered from the next count so they always describe count
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      step_done <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      count     <= count_next;
      step_done <= (count_next >= STEP_LAST);
      timeout   <= (count_next >= PG_LAST);
    end
  end

endmodule

// File: rtl/camera_power_ctrl.sv
// Image sensor power sequencer: command-driven rail/INCK/XCLR ramp-up and
// ramp-down with power-good supervision and a latched fault state.
module camera_power_ctrl
  import camera_power_pkg::*;
#(
  parameter int unsigned STEP_DELAY    = 1000000,
  parameter int unsigned PGOOD_TIMEOUT = 2000000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic       ctrl_clk_i,
  input  logic       ctrl_rst_i,
  input  logic       pwr_up_req_i,
  input  logic       pwr_dn_req_i,
  input  logic [2:0] pgood_i,
  output logic       reg_1v2_en_o,
  output logic       reg_1v8_en_o,
  output logic       reg_3v3_en_o,
  output logic       inck_en_o,
  output logic       xclr_o,
  output logic       busy_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [3:0] state_o
);

  state_t   state;
  state_t   state_next;
  pwr_out_t outs;
  pwr_out_t cur_dec;
  logic     step_done;
  logic     timeout;
  logic     step_clear;

  assign cur_dec    = decode_outputs(state);
  assign step_clear = (state_next != state);

  camera_power_step_timer #(
    .STEP_DELAY    (STEP_DELAY),
    .PGOOD_TIMEOUT (PGOOD_TIMEOUT),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk       (ctrl_clk_i),
    .rst       (ctrl_rst_i),
    .clear     (step_clear),
    .enable    (cur_dec.busy),
    .step_done (step_done),
    .timeout   (timeout)
  );

  // Next-state: down requests abort ramp-up; pgood gates each rail step
  always_comb begin
    state_next = state;
    case (state)
      ST_OFF:     if (pwr_up_req_i && !pwr_dn_req_i) state_next = ST_UP_1V2;
      ST_UP_1V2: begin
        if (pwr_dn_req_i)                          state_next = ST_DN_1V2;
        else if (step_done && pgood_i[PG_1V2])     state_next = ST_UP_1V8;
        else if (timeout)                          state_next = ST_FAULT;
      end
      ST_UP_1V8: begin
        if (pwr_dn_req_i)                          state_next = ST_DN_1V8;
        else if (step_done && pgood_i[PG_1V8])     state_next = ST_UP_3V3;
        else if (timeout)                          state_next = ST_FAULT;
      end
      ST_UP_3V3: begin
        if (pwr_dn_req_i)                          state_next = ST_DN_3V3;
        else if (step_done && pgood_i[PG_3V3])     state_next = ST_UP_INCK;
        else if (timeout)                          state_next = ST_FAULT;
      end
      ST_UP_INCK: begin
        if (pwr_dn_req_i)                          state_next = ST_DN_INCK;
        else if (step_done)                        state_next = ST_UP_XCLR;
      end
      ST_UP_XCLR: begin
        if (pwr_dn_req_i)                          state_next = ST_DN_XCLR;
        else if (step_done)                        state_next = ST_ON;
      end
      ST_ON: begin
        if (pgood_i != 3'b111)                     state_next = ST_FAULT;
        else if (pwr_dn_req_i)                     state_next = ST_DN_XCLR;
      end
      ST_DN_XCLR: if (step_done) state_next = ST_DN_INCK;
      ST_DN_INCK: if (step_done) state_next = ST_DN_3V3;
      ST_DN_3V3:  if (step_done) state_next = ST_DN_1V8;
      ST_DN_1V8:  if (step_done) state_next = ST_DN_1V2;
      ST_DN_1V2:  if (step_done) state_next = ST_OFF;
      ST_FAULT:   if (pwr_dn_req_i) state_next = ST_OFF;
      default:    state_next = ST_OFF;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  always_ff @(posedge ctrl_clk_i) begin
    if (ctrl_rst_i) begin
      state <= ST_OFF;
      outs  <= '0;
    end else begin
      state <= state_next;
      outs  <= decode_outputs(state_next);
    end
  end

  assign reg_1v2_en_o = outs.reg_1v2_en;
  assign reg_1v8_en_o = outs.reg_1v8_en;
  assign reg_3v3_en_o = outs.reg_3v3_en;
  assign inck_en_o    = outs.inck_en;
  assign xclr_o       = outs.xclr;
  assign busy_o       = outs.busy;
  assign ready_o      = outs.ready;
  assign fault_o      = outs.fault;
  assign state_o      = state;

endmodule

// File: tb/tb_camera_power_ctrl.sv
// Bench for camera_power_ctrl: vector table, timed corner sequences and
// randomized traffic against a rail-level reference model.
module tb_camera_power_ctrl;

  localparam int SD  = 4;
  localparam int PGT = 16;
  localparam int DIR_IDLE = 0;
  localparam int DIR_UP   = 1;
  localparam int DIR_DN   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up  = 1'b0;
  logic       dn  = 1'b0;
  logic [2:0] pg  = 3'b000;
  logic       r12, r18, r33, inck, xclr, busy, ready, fault;
  logic [3:0] state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: number of items powered (0..5), ramp direction, dwell, fault flag
  int m_level = 0;
  int m_dir   = DIR_IDLE;
  int m_dwell = 0;
  bit m_fault = 1'b0;

  int t_on[5];
  int t_off[5];
  int t_rdy, t_flt, t_st0;

  typedef struct {
    logic        r;
    logic        u;
    logic        d;
    logic [2:0]  p;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl[11];

  always #5 clk = ~clk;

  camera_power_ctrl #(
    .STEP_DELAY    (SD),
    .PGOOD_TIMEOUT (PGT),
    .CNT_W         (32)
  ) dut (
    .ctrl_clk_i   (clk),
    .ctrl_rst_i   (rst),
    .pwr_up_req_i (up),
    .pwr_dn_req_i (dn),
    .pgood_i      (pg),
    .reg_1v2_en_o (r12),
    .reg_1v8_en_o (r18),
    .reg_3v3_en_o (r33),
    .inck_en_o    (inck),
    .xclr_o       (xclr),
    .busy_o       (busy),
    .ready_o      (ready),
    .fault_o      (fault),
    .state_o      (state)
  );

  function automatic logic [11:0] dut_vec();
    return {r12, r18, r33, inck, xclr, busy, ready, fault, state};
  endfunction

  function automatic logic [11:0] model_vec();
    logic [4:0] en;
    logic [3:0] st;
    logic       b, rd;
    for (int i = 0; i < 5; i++) en[i] = !m_fault && (m_level > i);
    b  = (m_dir != DIR_IDLE);
    rd = (m_dir == DIR_IDLE) && (m_level == 5) && !m_fault;
    if (m_fault)              st = 4'd12;
    else if (m_dir == DIR_UP) st = 4'(m_level);
    else if (m_dir == DIR_DN) st = 4'(11 - m_level);
    else if (m_level == 5)    st = 4'd6;
    else                      st = 4'd0;
    return {en[0], en[1], en[2], en[3], en[4], b, rd, m_fault, st};
  endfunction

  task automatic model_step(input logic r, input logic u, input logic d, input logic [2:0] p);
    bit chg;
    chg = 1'b0;
    if (r) begin
      m_level = 0; m_dir = DIR_IDLE; m_fault = 1'b0; m_dwell = 0;
      return;
    end
    if (m_fault) begin
      if (d) begin m_fault = 1'b0; chg = 1'b1; end
    end else if (m_dir == DIR_IDLE && m_level == 0) begin
      if (u && !d) begin m_dir = DIR_UP; m_level = 1; chg = 1'b1; end
    end else if (m_dir == DIR_IDLE) begin
      if (p != 3'b111) begin m_fault = 1'b1; m_level = 0; chg = 1'b1; end
      else if (d) begin m_dir = DIR_DN; m_level = 4; chg = 1'b1; end
    end else if (m_dir == DIR_UP) begin
      if (d) begin
        m_dir = DIR_DN; m_level = m_level - 1; chg = 1'b1;
      end else if (m_dwell >= SD - 1 && (m_level > 3 || p[m_level-1])) begin
        if (m_level == 5) m_dir = DIR_IDLE;
        else m_level = m_level + 1;
        chg = 1'b1;
      end else if (m_level <= 3 && m_dwell >= PGT - 1) begin
        m_fault = 1'b1; m_level = 0; m_dir = DIR_IDLE; chg = 1'b1;
      end
    end else begin
      if (m_dwell >= SD - 1) begin
        if (m_level == 0) m_dir = DIR_IDLE;
        else m_level = m_level - 1;
        chg = 1'b1;
      end
    end
    m_dwell = chg ? 0 : m_dwell + 1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_track();
    for (int i = 0; i < 5; i++) begin t_on[i] = -1; t_off[i] = -1; end
    t_rdy = -1; t_flt = -1; t_st0 = -1;
  endtask

  task automatic cycle(input logic r, input logic u, input logic d, input logic [2:0] p);
    logic [4:0] en;
    rst = r; up = u; dn = d; pg = p;
    @(posedge clk);
    model_step(r, u, d, p);
    cyc++;
    @(negedge clk);
    rst = 1'b0; up = 1'b0; dn = 1'b0;
    check("model", 32'(dut_vec()), 32'(model_vec()));
    en = {xclr, inck, r33, r18, r12};
    for (int i = 0; i < 5; i++) begin
      if (en[i] && t_on[i] < 0) t_on[i] = cyc;
      if (!en[i] && t_off[i] < 0) t_off[i] = cyc;
    end
    if (ready && t_rdy < 0) t_rdy = cyc;
    if (fault && t_flt < 0) t_flt = cyc;
    if (state == 4'd0 && t_st0 < 0) t_st0 = cyc;
  endtask

  int         t0;
  logic       ru, rd, rr;
  logic [2:0] rp, pg_base;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'b111, 12'h000};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 3'b111, 12'h000};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 3'b111, 12'h000};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 3'b111, 12'b1000_0100_0001};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 3'b111, 12'b1000_0100_0001};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 3'b000, 12'b1000_0100_0001};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 3'b000, 12'b1000_0100_0001};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 3'b001, 12'b1100_0100_0010};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 3'b001, 12'b1000_0100_1010};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 3'b001, 12'b1000_0100_1010};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 3'b111, 12'h000};

    clear_track();
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].r, tbl[i].u, tbl[i].d, tbl[i].p);
      check($sformatf("vec%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
    end

    // Nominal power-up timing with pgood high
    cycle(1'b0, 1'b0, 1'b0, 3'b111);
    t0 = cyc; clear_track();
    cycle(1'b0, 1'b1, 1'b0, 3'b111);
    repeat (24) cycle(1'b0, 1'b0, 1'b0, 3'b111);
    check("up_1v2",   32'(t_on[0] - t0), 32'd1);
    check("up_1v8",   32'(t_on[1] - t0), 32'd5);
    check("up_3v3",   32'(t_on[2] - t0), 32'd9);
    check("up_inck",  32'(t_on[3] - t0), 32'd13);
    check("up_xclr",  32'(t_on[4] - t0), 32'd17);
    check("up_ready", 32'(t_rdy - t0),   32'd21);

    // Nominal power-down timing
    t0 = cyc; clear_track();
    cycle(1'b0, 1'b0, 1'b1, 3'b111);
    repeat (24) cycle(1'b0, 1'b0, 1'b0, 3'b111);
    check("dn_xclr", 32'(t_off[4] - t0), 32'd1);
    check("dn_inck", 32'(t_off[3] - t0), 32'd5);
    check("dn_3v3",  32'(t_off[2] - t0), 32'd9);
    check("dn_1v8",  32'(t_off[1] - t0), 32'd13);
    check("dn_1v2",  32'(t_off[0] - t0), 32'd17);
    check("dn_off",  32'(t_st0 - t0),    32'd21);

    // pgood[1] never arrives: timeout into FAULT, then clear
    t0 = cyc; clear_track();
    cycle(1'b0, 1'b1, 1'b0, 3'b001);
    repeat (24) cycle(1'b0, 1'b0, 1'b0, 3'b001);
    check("flt_time", 32'(t_flt - t0), 32'd21);
    check("flt_outs", 32'(dut_vec()), 32'h01C);
    cycle(1'b0, 1'b1, 1'b0, 3'b001);
    check("flt_up_ignored", 32'(state), 32'd12);
    cycle(1'b0, 1'b0, 1'b1, 3'b001);
    check("flt_clear", 32'({fault, state}), 32'd0);

    // pgood[2] arrives late, 9 cycles into UP_3V3
    t0 = cyc;
    cycle(1'b0, 1'b1, 1'b0, 3'b011);
    while (cyc < t0 + 17) cycle(1'b0, 1'b0, 1'b0, 3'b011);
    check("late_wait", 32'(state), 32'd3);
    cycle(1'b0, 1'b0, 1'b0, 3'b111);
    check("late_adv", 32'(state), 32'd4);
    check("late_nofault", 32'(fault), 32'd0);
    repeat (12) cycle(1'b0, 1'b0, 1'b0, 3'b111);
    check("late_on", 32'(ready), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 3'b111);
    repeat (22) cycle(1'b0, 1'b0, 1'b0, 3'b111);
    check("late_off", 32'(state), 32'd0);

    // Abort during UP_3V3
    t0 = cyc;
    cycle(1'b0, 1'b1, 1'b0, 3'b111);
    while (cyc < t0 + 10) cycle(1'b0, 1'b0, 1'b0, 3'b111);
    cycle(1'b0, 1'b0, 1'b1, 3'b111);
    check("abort_state", 32'(state), 32'd9);
    check("abort_3v3", 32'(r33), 32'd0);
    check("abort_1v8", 32'(r18), 32'd1);
    repeat (14) cycle(1'b0, 1'b0, 1'b0, 3'b111);
    check("abort_off", 32'(state), 32'd0);

    // Reset while ON
    cycle(1'b0, 1'b1, 1'b0, 3'b111);
    repeat (22) cycle(1'b0, 1'b0, 1'b0, 3'b111);
    check("pre_rst_on", 32'(ready), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 3'b111);
    check("rst_on", 32'(dut_vec()), 32'd0);

    // Randomized traffic with pgood held in phases
    pg_base = 3'b111;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 40) == 0) pg_base = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      ru = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 24) == 0);
      rr = ($urandom_range(0, 499) == 0);
      rp = ($urandom_range(0, 29) == 0) ? 3'($urandom_range(0, 7)) : pg_base;
      cycle(rr, ru, rd, rp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/camera_power_ctrl.md
# camera_power_ctrl

Software-controlled power sequencer for the image sensor. It drives the 1V2, 1V8 and 3V3 regulator enables, the INCK clock enable and XCLR. Power-up runs in the order 1V2 → 1V8 → 3V3 → INCK → XCLR release, with regulator power-good checks. Power-down runs in the reverse order. It sits between the Nios II control registers (request/status) and the camera board I/O, and replaces free-running sequencing at reset with explicit up/down commands and fault handling.

## Interface
- STEP_DELAY, 1000000: cycles held in each sequencing step (minimum 2).
- PGOOD_TIMEOUT, 2000000: cycles allowed for a rail's power-good after its enable (must be > STEP_DELAY).
- CNT_W, 32: step counter width.

- ctrl_clk_i  in  1  control clock.
- ctrl_rst_i  in  1  reset, synchronous, active-high.
- pwr_up_req_i  in  1  single-cycle power-up command.
- pwr_dn_req_i  in  1  single-cycle power-down / fault-clear command.
- pgood_i  in  3  power-good: [0]=1V2, [1]=1V8, [2]=3V3; synchronised upstream.
- reg_1v2_en_o  out  1  1V2 regulator enable.
- reg_1v8_en_o  out  1  1V8 regulator enable.
- reg_3v3_en_o  out  1  3V3 regulator enable.
- inck_en_o  out  1  sensor input clock enable.
- xclr_o  out  1  sensor XCLR; 1 = released.
- busy_o  out  1  sequence in progress.
- ready_o  out  1  sensor fully powered (state ON).
- fault_o  out  1  sequence aborted on a power-good failure.
- state_o  out  4  current state encoding, for status register.

## Operation
- States: OFF, UP_1V2, UP_1V8, UP_3V3, UP_INCK, UP_XCLR, ON, DN_XCLR, DN_INCK, DN_3V3, DN_1V8, DN_1V2, FAULT.
- Outputs are a pure decode of state:
  - reg_1v2_en_o is 1 in UP_1V2..DN_1V8.
  - reg_1v8_en_o is 1 in UP_1V8..DN_3V3.
  - reg_3v3_en_o is 1 in UP_3V3..DN_INCK.
  - inck_en_o is 1 in UP_INCK..DN_XCLR.
  - xclr_o is 1 in UP_XCLR and ON only.
  - In a DN_x state, rail x is already off.
- OFF:
  - pwr_up_req_i → UP_1V2.
  - pwr_dn_req_i is ignored.
  - If both requests are set in the same cycle, down wins and the block stays in OFF.
- UP_1V2 / UP_1V8 / UP_3V3:
  - Advance to the next state once count ≥ STEP_DELAY−1 and the matching pgood bit is 1.
  - If count reaches PGOOD_TIMEOUT−1 without pgood → FAULT.
- UP_INCK and UP_XCLR: advance when count = STEP_DELAY−1. UP_XCLR → ON.
- ON:
  - pwr_dn_req_i → DN_XCLR.
  - Any pgood bit at 0 → FAULT, which takes priority over the request.
- DN_* states: each holds for STEP_DELAY cycles, then moves down the chain. DN_1V2 → OFF. pgood is ignored.
- Abort during power-up: pwr_dn_req_i in UP_x enters the down step that removes the highest item currently on.
  - UP_1V2 → DN_1V2, UP_1V8 → DN_1V8, UP_3V3 → DN_3V3, UP_INCK → DN_INCK, UP_XCLR → DN_XCLR.
- Requests in non-ready states:
  - pwr_up_req_i in any state other than OFF is ignored.
  - pwr_dn_req_i in a DN_* state is ignored.
- FAULT:
  - All enables are 0 and fault_o is 1.
  - Only pwr_dn_req_i exits, to OFF (acknowledged fault clear).
- Counter clears to 0 on every state change and saturates at its maximum.

## Timing
- Reset: state OFF, counter 0, all outputs 0, including xclr_o (sensor held in reset).
- State and all outputs are registered. A request sampled on edge N makes the new state and its outputs visible after edge N. There is no extra output latency.
- busy_o is 1 in every UP_* and DN_* state.
- With pgood tied high, rail enables rise STEP_DELAY cycles apart:
  - xclr_o rises 4·STEP_DELAY cycles after reg_1v2_en_o.
  - ready_o rises 5·STEP_DELAY cycles after reg_1v2_en_o.
- Power-good timing:
  - pgood arriving late, but before the timeout, advances on the first cycle it is sampled high.
  - A pgood bit dropping in ON gives FAULT, with all outputs 0, one edge later.
- Reset asserted mid-sequence forces OFF and all outputs to 0 on that edge. There is no graceful ramp-down.

## Structure
- Package camera_power_pkg: state enum (4-bit encoding, exported on state_o) and the pgood bit-index constants PG_1V2=0, PG_1V8=1, PG_3V3=2.
- Sub-module camera_power_step_timer holds the counter:
  - inputs: clear, enable
  - outputs: step_done (count ≥ STEP_DELAY−1) and timeout (count ≥ PGOOD_TIMEOUT−1)
  - the counter is CNT_W bits wide and saturating.

## Test plan
All scenarios use STEP_DELAY=4 and PGOOD_TIMEOUT=16.
- Nominal up with pgood=3'b111, up pulse at cycle 10:
  - 1V2 enable at 11, 1V8 at 15, 3V3 at 19, INCK at 23, XCLR at 27, ready_o at 31.
- Down from ON, dn pulse at cycle T:
  - xclr_o drops at T+1, inck_en_o at T+5, 3V3 at T+9, 1V8 at T+13, 1V2 at T+17, OFF.
- pgood[1] held 0 during UP_1V8:
  - FAULT 16 cycles after UP_1V8 entry; all enables 0; fault_o=1.
  - An up pulse is ignored; a dn pulse returns to OFF with fault_o=0.
- Late pgood[2] arriving 9 cycles into UP_3V3: advance to UP_INCK on the next edge, no fault.
- Abort: dn pulse during UP_3V3 → DN_3V3 with 3V3 off immediately; then the normal ramp-down to OFF.
- Simultaneous up+dn in OFF stays in OFF. Reset pulse while in ON: all outputs 0 on the next edge, state_o = OFF.
